// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the bit-serial ADDF adder: the control
//               state encoding and the widest legal operand size.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // 2'd3 is unused; the controller treats it as illegal and returns to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 64;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/ADDF.sv
`default_nettype none
// ============================================================================
// Module      : ADDF
// Description : 1-bit full-adder library cell.
// Ports       : A, B, CI  - addend bits and carry-in
//               SUM       - A ^ B ^ CI
//               CO        - majority(A, B, CI)
// Revision    : 1.0 - initial release
// ============================================================================
module ADDF (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic SUM,
    output logic CO
);

    assign SUM = A ^ B ^ CI;
    assign CO  = (A & B) | (CI & (A ^ B));

endmodule : ADDF
`default_nettype wire

// File: rtl/serial_addf_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_addf_adder
// Description : Bit-serial WIDTH-bit adder built around one ADDF cell. Operands
//               are latched on an input handshake, added LSB first at one bit
//               per clock, and the result {CO,SUM} = A+B+CI is offered on a
//               valid/ready output handshake.
// Ports       : CK, RSTN             - clock (rising), async active-low reset
//               IN_VALID / IN_READY  - operand handshake (A, B, CI)
//               OUT_VALID / OUT_READY- result handshake (SUM, CO)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addf_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CO
);

    if ((WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
        $error("serial_addf_adder: WIDTH out of range 1..64");
    end

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;

    logic             w_s;
    logic             w_co;

    ADDF u_addf (
        .A   (r_a_sh[0]),
        .B   (r_b_sh[0]),
        .CI  (r_carry),
        .SUM (w_s),
        .CO  (w_co)
    );

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_carry <= CI;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    // New sum bit enters at the MSB; after WIDTH shifts bit 0
                    // has walked down to SUM[0]. Written as a shift of the
                    // concatenation so WIDTH=1 needs no special case.
                    r_sum   <= WIDTH'({w_s, r_sum} >> 1);
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_last) begin
                        r_co    <= w_co;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode the state only, so neither depends on the inputs.
    assign IN_READY  = (r_state == ST_IDLE);
    assign OUT_VALID = (r_state == ST_DONE);
    assign SUM       = r_sum;
    assign CO        = r_co;

endmodule : serial_addf_adder
`default_nettype wire

// File: tb/tb_serial_addf_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addf_adder
// Description : Self-checking bench for serial_addf_adder. Three instances
//               (WIDTH 8, 13, 1) share clock and reset; results are compared
//               with A+B+CI computed directly in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addf_adder;

    logic CK;
    logic RSTN;

    logic [2:0]       iv;
    logic [2:0]       ordy;
    logic [2:0]       ci;
    logic [2:0][12:0] a;
    logic [2:0][12:0] b;
    wire  [2:0]       ir;
    wire  [2:0]       ov;
    wire  [2:0]       co;
    wire  [7:0]       sum8;
    wire  [12:0]      sum13;
    wire  [0:0]       sum1;

    int checks = 0;
    int errors = 0;
    int wtab[3] = '{8, 13, 1};

    serial_addf_adder #(.WIDTH(8)) u_dut8 (
        .CK(CK), .RSTN(RSTN), .IN_VALID(iv[0]), .IN_READY(ir[0]),
        .A(a[0][7:0]), .B(b[0][7:0]), .CI(ci[0]), .OUT_VALID(ov[0]),
        .OUT_READY(ordy[0]), .SUM(sum8), .CO(co[0])
    );

    serial_addf_adder #(.WIDTH(13)) u_dut13 (
        .CK(CK), .RSTN(RSTN), .IN_VALID(iv[1]), .IN_READY(ir[1]),
        .A(a[1]), .B(b[1]), .CI(ci[1]), .OUT_VALID(ov[1]),
        .OUT_READY(ordy[1]), .SUM(sum13), .CO(co[1])
    );

    serial_addf_adder #(.WIDTH(1)) u_dut1 (
        .CK(CK), .RSTN(RSTN), .IN_VALID(iv[2]), .IN_READY(ir[2]),
        .A(a[2][0:0]), .B(b[2][0:0]), .CI(ci[2]), .OUT_VALID(ov[2]),
        .OUT_READY(ordy[2]), .SUM(sum1), .CO(co[2])
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // {CO,SUM} of instance d as an integer.
    function automatic int get_res(input int d);
        case (d)
            0:       return int'({co[0], sum8});
            1:       return int'({co[1], sum13});
            default: return int'({co[2], sum1});
        endcase
    endfunction

    // Reference: exact unsigned sum, WIDTH+1 bits wide.
    function automatic int model(input int d, input int av, input int bv, input int cv);
        int mask;
        mask = (1 << wtab[d]) - 1;
        return (av & mask) + (bv & mask) + (cv & 1);
    endfunction

    // Drives one operand set into instance d and waits for its result.
    // Called and returning at a falling edge; OUT_READY is the caller's.
    task automatic do_op(input int d, input int av, input int bv, input int cv,
                         output int lat, output int res, output bit to);
        int g;
        to  = 1'b0;
        lat = 0;
        g   = 0;
        while (!ir[d] && g < 200) begin
            @(posedge CK); @(negedge CK); g++;
        end
        if (g >= 200) to = 1'b1;
        a[d] = 13'(av); b[d] = 13'(bv); ci[d] = cv[0]; iv[d] = 1'b1;
        @(posedge CK); @(negedge CK);
        iv[d] = 1'b0;
        a[d] = 13'($urandom); b[d] = 13'($urandom); ci[d] = 1'($urandom);
        while (!ov[d] && lat < 200) begin
            @(posedge CK); lat++; @(negedge CK);
        end
        if (lat >= 200) to = 1'b1;
        res = get_res(d);
    endtask

    task automatic test_reset;
        RSTN = 1'b0;
        repeat (3) @(negedge CK);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || get_res(d) !== 0) begin
                errors++;
                $display("FAIL reset_state dut%0d: ir=%b ov=%b res=%0h, want ir=1 ov=0 res=0",
                         d, ir[d], ov[d], get_res(d));
            end
        end
        RSTN = 1'b1;
        @(negedge CK);
    endtask

    task automatic test_basic;
        int lat, res; bit to;
        ordy[0] = 1'b1;
        do_op(0, 'h3C, 'h0F, 0, lat, res, to);
        checks++;
        if (to || lat !== 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d (timeout=%0b), want 8", lat, to);
        end
        checks++;
        if (res !== 'h04B) begin
            errors++;
            $display("FAIL basic_result: got %0h, want 04b", res);
        end
        @(posedge CK); @(negedge CK);
        checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_again: ir=%b ov=%b, want ir=1 ov=0", ir[0], ov[0]);
        end
    endtask

    task automatic test_carry_ripple;
        int lat, res; bit to;
        ordy[0] = 1'b1;
        do_op(0, 'hFF, 'h00, 1, lat, res, to);
        checks++;
        if (to || res !== 'h100) begin
            errors++;
            $display("FAIL carry_ripple: got %0h (timeout=%0b), want 100", res, to);
        end
        @(posedge CK); @(negedge CK);
    endtask

    task automatic test_stall;
        int lat, res, bad; bit to;
        ordy[0] = 1'b0;
        do_op(0, 'hA5, 'h5A, 1, lat, res, to);
        checks++;
        if (to || res !== 'h100) begin
            errors++;
            $display("FAIL stall_result: got %0h (timeout=%0b), want 100", res, to);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            iv[0] = i[0];
            a[0] = 13'($urandom); b[0] = 13'($urandom); ci[0] = 1'($urandom);
            @(posedge CK); @(negedge CK);
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || get_res(0) !== 'h100) bad++;
        end
        iv[0] = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold: %0d unstable cycles, want 0", bad);
        end
        ordy[0] = 1'b1;
        @(posedge CK); @(negedge CK);
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: ov=%b ir=%b, want ov=0 ir=1", ov[0], ir[0]);
        end
    endtask

    task automatic test_reset_abort;
        int lat, res, seen; bit to;
        ordy[0] = 1'b1;
        a[0] = 13'h0FF; b[0] = 13'h001; ci[0] = 1'b1; iv[0] = 1'b1;
        @(posedge CK); @(negedge CK);
        iv[0] = 1'b0;
        @(posedge CK); @(posedge CK); @(posedge CK);
        #1 RSTN = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || get_res(0) !== 0) begin
            errors++;
            $display("FAIL abort_async: ov=%b ir=%b res=%0h, want 0 1 0", ov[0], ir[0], get_res(0));
        end
        @(negedge CK);
        RSTN = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CK); @(negedge CK);
            if (ov[0] !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_spurious_valid: %0d cycles, want 0", seen);
        end
        do_op(0, 'h01, 'h01, 0, lat, res, to);
        checks++;
        if (to || res !== 'h002) begin
            errors++;
            $display("FAIL abort_next_result: got %0h (timeout=%0b), want 002", res, to);
        end
        @(posedge CK); @(negedge CK);
    endtask

    task automatic test_width1;
        int lat, res; bit to;
        ordy[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            do_op(2, k & 1, (k >> 1) & 1, (k >> 2) & 1, lat, res, to);
            checks++;
            if (to || lat !== 1 || res !== model(2, k & 1, (k >> 1) & 1, (k >> 2) & 1)) begin
                errors++;
                $display("FAIL width1_k%0d: res=%0d lat=%0d, want res=%0d lat=1",
                         k, res, lat, model(2, k & 1, (k >> 1) & 1, (k >> 2) & 1));
            end
            @(posedge CK); @(negedge CK);
        end
    endtask

    task automatic test_back_to_back(input int d, input int nops);
        int exp_q[$];
        int acc_cyc, cyc, nin, nout, av, bv, cv, got, budget, lat_bad;
        bit prev_ov;
        cyc = 0; nin = 0; nout = 0; acc_cyc = 0; lat_bad = 0; prev_ov = 1'b0;
        budget = nops * (wtab[d] + 12) + 200;
        while (nout < nops && cyc < budget) begin
            // Output side: what the DUT sees at the next rising edge.
            ordy[d] = 1'($urandom);
            if (ov[d] === 1'b1 && !prev_ov && (cyc - acc_cyc) != wtab[d]) lat_bad++;
            prev_ov = (ov[d] === 1'b1) && !ordy[d];
            if (ov[d] === 1'b1 && ordy[d]) begin
                got = get_res(d);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_w%0d_dup: unexpected result %0h", wtab[d], got);
                end else if (got !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_w%0d_result: got %0h, want %0h", wtab[d], got, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                nout++;
            end
            // Input side.
            av = int'($urandom); bv = int'($urandom); cv = int'($urandom_range(0, 1));
            a[d] = 13'(av); b[d] = 13'(bv); ci[d] = cv[0];
            iv[d] = (nin < nops) ? 1'($urandom) : 1'b0;
            if (iv[d] && ir[d] === 1'b1) begin
                exp_q.push_back(model(d, av, bv, cv));
                acc_cyc = cyc + 1;
                nin++;
            end
            @(posedge CK); cyc++; @(negedge CK);
        end
        iv[d] = 1'b0;
        checks++;
        if (nout !== nops || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_w%0d_count: out=%0d pending=%0d, want out=%0d pending=0",
                     wtab[d], nout, exp_q.size(), nops);
        end
        checks++;
        if (lat_bad !== 0) begin
            errors++;
            $display("FAIL b2b_w%0d_latency: %0d wrong latencies, want 0", wtab[d], lat_bad);
        end
        ordy[d] = 1'b1;
        @(posedge CK); @(negedge CK);
    endtask

    initial begin
        iv = '0; ordy = '0; ci = '0; a = '0; b = '0;
        RSTN = 1'b0;
        @(negedge CK);
        test_reset();
        test_basic();
        test_carry_ripple();
        test_stall();
        test_reset_abort();
        test_width1();
        test_back_to_back(0, 800);
        test_back_to_back(1, 800);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_addf_adder
`default_nettype wire
